// File: rtl/multicycle_mem.sv
// multicycle_mem: fixed-latency, single-outstanding 16-bit word memory responder.
// Latency: a request accepted on edge N completes with a one-cycle ack in cycle N+LATENCY.
// Backpressure: busy is high while a request is in flight; enable is ignored while busy.
module multicycle_mem #(
   parameter int LATENCY = 4,   // 2..15
   parameter int INDEX_W = 10   // array depth is 2**INDEX_W words; 1..14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        ack,
   output logic        busy
);

   localparam int         DEPTH  = 1 << INDEX_W;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 w_accept;
   logic                 w_commit;

   logic [3:0]           r_cnt;
   logic                 r_wr;
   logic [INDEX_W-1:0]   r_idx;
   logic [15:0]          r_wdata;
   logic [15:0]          r_rdata;
   logic [15:0]          r_mem [DEPTH];

   logic [INDEX_W-1:0]   w_idx;

   // Byte address to word index: bit 0 and the bits above the array are dropped,
   // so odd addresses alias the even word and addresses wrap around the array.
   assign w_idx = addr[INDEX_W:1];

   generate
      if (INDEX_W < 15) begin : g_addr_hi
         logic w_unused_addr;
         assign w_unused_addr = ^{addr[15:INDEX_W+1], addr[0]};
      end else begin : g_addr_lo
         logic w_unused_addr;
         assign w_unused_addr = addr[0];
      end
   endgenerate

   // State register; reset drops any in-flight request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode. DONE accepts a new request exactly like IDLE, which is
   // what allows one request per LATENCY cycles. Outputs are pure state decode,
   // so nothing reaches ack/busy combinationally from enable.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_commit = 1'b0;
      busy     = 1'b0;
      ack      = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            ack = (r_state == DONE);
            if (enable) begin
               w_accept = 1'b1;
               w_next   = WAIT;
            end else begin
               w_next   = IDLE;
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (r_cnt == 4'd1) begin
               w_commit = 1'b1;
               w_next   = DONE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Latency counter: loaded on acceptance, counts down while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 4'd0;
      end else if (w_accept) begin
         r_cnt <= LAT_M1;
      end else if (r_state == WAIT) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Request capture; inputs only need to be valid on the acceptance edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= 16'h0000;
      end else if (w_accept) begin
         r_wr    <= wr;
         r_idx   <= w_idx;
         r_wdata <= data_in;
      end
   end

   // Storage array. Writes commit only at the end of the wait, so a reset
   // during the wait discards the pending write; reset also clears every word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 16'h0000;
         end
      end else if (w_commit && r_wr) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   // Read data register: updated only by completing reads, held across writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= 16'h0000;
      end else if (w_commit && !r_wr) begin
         r_rdata <= r_mem[r_idx];
      end
   end

   assign data_out = r_rdata;

endmodule

// File: doc/multicycle_mem.md
Name: multicycle_mem

Overview:
- Fixed-latency, single-outstanding data/instruction memory responder.
- It is the target side of the memory request interface that the CPU drives: enable, wr, addr and data_in.
- It replaces the zero-wait memory model once the CPU gains stall logic.
- Each accepted request completes LATENCY cycles later with a one-cycle ack. Busy is held in between so the initiator stalls.

Parameters:
- LATENCY, 4, cycles from request acceptance to ack. Legal range 2..15.
- INDEX_W, 10, word-index width. Array depth is 2^INDEX_W 16-bit words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  request valid; sampled only when busy=0.
- wr  in  1  1=write, 0=read; qualified by enable.
- addr  in  16  byte address.
- data_in  in  16  write data.
- data_out  out  16  read data of the most recent completed read.
- ack  out  1  one-cycle completion pulse for reads and writes.
- busy  out  1  request in flight; new requests are not accepted.

Behaviour:
- Reset (async, rst=1), applied immediately:
  - state=IDLE, busy=0, ack=0, data_out=16'h0000.
  - counter=0.
  - All array words are cleared to 0.
  - Any in-flight request is discarded; a pending write is never committed.
- Addressing:
  - word index = addr[INDEX_W:1].
  - addr[0] is ignored, so odd addresses alias the even word.
  - addr[15:INDEX_W+1] are ignored, so addresses wrap modulo 2^(INDEX_W+1) bytes.
- States:
  - IDLE: busy=0.
    - On an edge with enable=1, latch wr, word index and data_in.
    - Load counter with LATENCY-1 and go to WAIT.
  - WAIT: busy=1.
    - Counter decrements each edge.
    - On the edge where counter=1, perform the operation and go to DONE:
      - write: array[idx] <= latched data.
      - read: data_out <= array[idx].
  - DONE: ack=1, busy=0 for exactly this cycle. This is the same cycle as IDLE with respect to acceptance.
    - enable=1 here is accepted: go to WAIT and load the counter.
    - Otherwise go to IDLE.
- Timing: request presented in cycle N with busy=0.
  - busy=1 in cycles N+1 .. N+LATENCY-1.
  - ack=1 and new data_out in cycle N+LATENCY.
  - Peak throughput is one request per LATENCY cycles.
- enable while busy=1: ignored completely. No latch, no state change, no side effect.
- data_out holds its value until the next read completes. Write completions do not change data_out.
- ack and busy are never both 1.
- Ordering: operations commit in acceptance order, and only one is in flight.
  - A read issued on the ack cycle of a write to the same word returns the new data.
- Inputs need only be stable in the acceptance cycle; later changes are ignored.
- rst asserted mid-WAIT:
  - Outputs return to reset values asynchronously.
  - After rst deasserts, the first edge may accept a new request.
- ack, busy and data_out are driven from registers or state decode only. There is no combinational path from enable.

Test Plan:
- Reset then read: rst pulse, read addr 16'h0020 in cycle N.
  - Expect busy=1 in N+1..N+3.
  - Expect ack=1 and data_out=16'h0000 in N+4.
  - Expect ack=0 and busy=0 in N+5.
- Write then read-back on ack cycle:
  - Write 16'hBEEF to 16'h0010; ack in N+4, data_out unchanged.
  - Read 16'h0011 issued in N+4; ack in N+8 with data_out=16'hBEEF (odd-address alias).
- Request during busy ignored:
  - Read 16'h0010 in N.
  - enable=1, wr=1, data_in=16'h1234 to 16'h0010 in N+2.
  - Only one ack (N+4).
  - A subsequent read of 16'h0010 returns the prior value, not 16'h1234.
- Wrap-around with INDEX_W=10:
  - Write 16'hA5A5 to 16'h0802.
  - Read 16'h0002 returns 16'hA5A5.
- Reset mid-write:
  - Write 16'h5555 to 16'h0040 in N; rst=1 in N+2 for one cycle.
  - Expect busy=0, ack=0 and data_out=0 immediately.
  - A later read of 16'h0040 returns 16'h0000 and no ack appears for the aborted write.
- LATENCY=2 build:
  - Back-to-back reads every 2 cycles.
  - ack pulses in N+2, N+4, N+6; busy=1 only in N+1, N+3, N+5.
